// File: rtl/checker_pkg.sv
// Shared types and helpers for the exhaustive stimulus checker.
// Holds the FSM state enum, latency bound and saturating increment.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } chk_state_t;

  localparam int LAT_MAX = 15;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register of {valid, data}; DEPTH=0 is a wire.
// Ports: clk, rst_n, flush (sync, clears valids), in_*/out_* tagged data.
module delay_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused    = ^{clk, rst_n, flush};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_sr
    logic [DEPTH-1:0] vld;
    logic [DW-1:0]    dat [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          dat[i] <= '0;
        end
      end else begin
        vld[0] <= flush ? 1'b0 : in_valid;
        dat[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld[i] <= flush ? 1'b0 : vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
  end

endmodule

// File: rtl/exhaustive_checker.sv
// Sweeps all 2^WIDTH vectors into a DUT and checks it against a reference.
// Ports: start/stop_on_err in, stim out, dut_o/ref_o in, status/err out.
module exhaustive_checker
  import checker_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int OUT_W = 1,
  parameter int LAT   = 1,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_err,
  output logic [WIDTH-1:0] stim,
  input  logic [OUT_W-1:0] dut_o,
  input  logic [OUT_W-1:0] ref_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_vec
);

  localparam int DW = WIDTH + OUT_W;
  localparam int CW = $clog2(LAT_MAX + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_t state, state_nxt;

  logic             stop_lat;
  logic             accept;
  logic             finish;
  logic             last_vec;
  logic             cmp_en;
  logic             mismatch;
  logic             abort;
  logic [CW-1:0]    drain_cnt;
  logic             d_valid;
  logic [DW-1:0]    d_data;
  logic [WIDTH-1:0] d_vec;
  logic [OUT_W-1:0] d_ref;

  assign last_vec = (stim == '1);

  delay_line #(
    .DW   (DW),
    .DEPTH(LAT)
  ) u_dl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (accept | abort),
    .in_valid (state == RUN),
    .in_data  ({stim, ref_o}),
    .out_valid(d_valid),
    .out_data (d_data)
  );

  assign d_vec = d_data[DW-1:OUT_W];
  assign d_ref = d_data[OUT_W-1:0];

  // Tags can only be live while sweeping or draining.
  assign cmp_en   = d_valid && ((state == RUN) || (state == DRAIN));
  assign mismatch = cmp_en && (dut_o != d_ref);
  assign abort    = mismatch && stop_lat;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (last_vec) begin
          if (LAT == 0) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (drain_cnt == CW'(LAT - 1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim            <= '0;
      stop_lat        <= 1'b0;
      drain_cnt       <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      pass            <= 1'b0;
    end else if (accept) begin
      stim            <= '0;
      stop_lat        <= stop_on_err;
      drain_cnt       <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      pass            <= 1'b0;
    end else begin
      if ((state == RUN) && !last_vec) begin
        stim <= stim + WIDTH'(1);
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + CW'(1);
      end
      if (mismatch) begin
        err_cnt <= ERR_W'(sat_inc(32'(err_cnt), 32'(ERR_MAX)));
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= d_vec;
        end
      end
      // The final compare may coincide with completion.
      if (finish) begin
        pass <= !(first_err_valid || mismatch);
      end
    end
  end

endmodule

// File: tb/tb_exhaustive_checker.sv
// Self-checking bench: two checker instances against behavioural DUTs.
// Instance a: WIDTH=10 LAT=0 OR gate; instance b: WIDTH=4 LAT=3 ERR_W=4.
module tb_exhaustive_checker;

  logic clk;
  logic rst_n;

  logic          start_a, stop_a;
  logic [9:0]    stim_a, fvec_a;
  logic          dut_o_a, ref_o_a;
  logic          busy_a, done_a, pass_a, fev_a;
  logic [15:0]   err_a;
  logic [1023:0] bad_a;

  logic        start_b, stop_b;
  logic [3:0]  stim_b, fvec_b, dut_o_b, ref_o_b, fb, mask_b;
  logic        busy_b, done_b, pass_b, fev_b;
  logic [3:0]  err_b;
  logic [15:0] bad_b;
  logic [3:0]  pipe [3];
  int          dut_lat;

  int total;
  int bad;

  logic [9:0] a_stim1;
  logic       a_busy1;
  logic       a_seq_ok;
  logic [3:0] b_stim1;
  logic       b_busy1;

  exhaustive_checker #(
    .WIDTH(10), .OUT_W(1), .LAT(0), .ERR_W(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop_on_err(stop_a),
    .stim(stim_a), .dut_o(dut_o_a), .ref_o(ref_o_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_valid(fev_a), .first_err_vec(fvec_a)
  );

  exhaustive_checker #(
    .WIDTH(4), .OUT_W(4), .LAT(3), .ERR_W(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop_on_err(stop_b),
    .stim(stim_b), .dut_o(dut_o_b), .ref_o(ref_o_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_valid(fev_b), .first_err_vec(fvec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] fref(input logic [3:0] v);
    return v * 4'd7 + 4'd3;
  endfunction

  assign ref_o_a = |stim_a;
  assign dut_o_a = (|stim_a) ^ bad_a[stim_a];

  assign ref_o_b = fref(stim_b);
  assign fb      = ref_o_b ^ (bad_b[stim_b] ? mask_b : 4'h0);

  always @(posedge clk) begin
    pipe[0] <= fb;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  always_comb begin
    dut_o_b = pipe[2];
    if (dut_lat == 2) dut_o_b = pipe[1];
  end

  task automatic run_a(input int pulse_at, output int done_at);
    done_at  = -1;
    a_seq_ok = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      start_a = (n == pulse_at);
      if (n == 1) begin
        a_stim1 = stim_a;
        a_busy1 = busy_a;
      end
      if (n <= 1024 && (stim_a !== 10'(n - 1) || busy_a !== 1'b1))
        a_seq_ok = 1'b0;
      if (done_a) begin
        done_at = n;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic run_b(input logic stop, input int pulse_at,
                       output int done_at);
    done_at = -1;
    @(negedge clk);
    start_b = 1'b1;
    stop_b  = stop;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start_b = (n == pulse_at);
      if (n == 1) begin
        b_stim1 = stim_b;
        b_busy1 = busy_b;
      end
      if (done_b) begin
        done_at = n;
        break;
      end
    end
    start_b = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, fev_a, fvec_a} !== '0) begin
      bad++;
      $display("FAIL reset_a got stim=%0d busy=%0d done=%0d pass=%0d err=%0d fev=%0d want all 0",
               stim_a, busy_a, done_a, pass_a, err_a, fev_a);
    end
    total++;
    if ({stim_b, busy_b, done_b, pass_b, err_b, fev_b, fvec_b} !== '0) begin
      bad++;
      $display("FAIL reset_b got stim=%0d busy=%0d done=%0d pass=%0d err=%0d fev=%0d want all 0",
               stim_b, busy_b, done_b, pass_b, err_b, fev_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_or_sweep;
    int d;
    bad_a  = '0;
    stop_a = 1'b0;
    run_a(0, d);
    total++;
    if (a_stim1 !== 10'd0 || a_busy1 !== 1'b1) begin
      bad++;
      $display("FAIL or_first got stim=%0d busy=%0d want 0 1", a_stim1, a_busy1);
    end
    total++;
    if (a_seq_ok !== 1'b1) begin
      bad++;
      $display("FAIL or_seq got bad stim sequence want 0..1023");
    end
    total++;
    if (d != 1025) begin
      bad++;
      $display("FAIL or_done got %0d want 1025", d);
    end
    total++;
    if (pass_a !== 1'b1 || err_a !== 16'd0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL or_result got pass=%0d err=%0d busy=%0d want 1 0 0",
               pass_a, err_a, busy_a);
    end
  endtask

  task automatic test_latency;
    int d;
    bad_b   = '0;
    mask_b  = 4'h1;
    dut_lat = 3;
    run_b(1'b0, 0, d);
    total++;
    if (b_stim1 !== 4'd0 || b_busy1 !== 1'b1) begin
      bad++;
      $display("FAIL lat_first got stim=%0d busy=%0d want 0 1", b_stim1, b_busy1);
    end
    total++;
    if (d != 20 || pass_b !== 1'b1 || err_b !== 4'd0) begin
      bad++;
      $display("FAIL lat3 got done=%0d pass=%0d err=%0d want 20 1 0",
               d, pass_b, err_b);
    end
    dut_lat = 2;
    run_b(1'b0, 0, d);
    total++;
    if (d != 20 || pass_b !== 1'b0 || err_b === 4'd0) begin
      bad++;
      $display("FAIL align got done=%0d pass=%0d err=%0d want 20 0 nonzero",
               d, pass_b, err_b);
    end
    dut_lat = 3;
  endtask

  task automatic test_faults;
    int d, cnt, first;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) bad_b = 16'h0220;
      else         bad_b = 16'($urandom) & 16'($urandom);
      mask_b = 4'($urandom_range(1, 15));
      cnt   = 0;
      first = -1;
      for (int v = 0; v < 16; v++) begin
        if (bad_b[v]) begin
          cnt++;
          if (first < 0) first = v;
        end
      end
      run_b(1'b0, 0, d);
      total++;
      if (d != 20 || pass_b !== (cnt == 0)) begin
        bad++;
        $display("FAIL faults_done it=%0d got done=%0d pass=%0d want 20 %0d",
                 it, d, pass_b, cnt == 0);
      end
      total++;
      if (err_b !== 4'((cnt > 15) ? 15 : cnt)) begin
        bad++;
        $display("FAIL faults_cnt it=%0d got %0d want %0d", it, err_b, cnt);
      end
      total++;
      if (fev_b !== (cnt > 0) || (cnt > 0 && fvec_b !== 4'(first))) begin
        bad++;
        $display("FAIL faults_first it=%0d got v=%0d vec=%0d want %0d %0d",
                 it, fev_b, fvec_b, cnt > 0, first);
      end
    end
  endtask

  task automatic test_abort;
    int d, k;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        bad_b = 16'h0220;
      end else begin
        bad_b = 16'($urandom) & 16'($urandom);
        bad_b[$urandom_range(0, 15)] = 1'b1;
      end
      mask_b = 4'($urandom_range(1, 15));
      k = 0;
      while (!bad_b[k]) k++;
      run_b(1'b1, 0, d);
      total++;
      if (d != k + 5) begin
        bad++;
        $display("FAIL abort_done it=%0d got %0d want %0d", it, d, k + 5);
      end
      repeat (6) @(negedge clk);
      total++;
      if (err_b !== 4'd1 || pass_b !== 1'b0 || done_b !== 1'b1) begin
        bad++;
        $display("FAIL abort_state it=%0d got err=%0d pass=%0d done=%0d want 1 0 1",
                 it, err_b, pass_b, done_b);
      end
      total++;
      if (fev_b !== 1'b1 || fvec_b !== 4'(k)) begin
        bad++;
        $display("FAIL abort_vec it=%0d got %0d want %0d", it, fvec_b, k);
      end
    end
  endtask

  task automatic test_saturate;
    int d;
    bad_b  = '1;
    mask_b = 4'h8;
    run_b(1'b0, 0, d);
    repeat (3) @(negedge clk);
    total++;
    if (err_b !== 4'd15 || fvec_b !== 4'd0 || pass_b !== 1'b0) begin
      bad++;
      $display("FAIL saturate got err=%0d vec=%0d pass=%0d want 15 0 0",
               err_b, fvec_b, pass_b);
    end
  endtask

  task automatic test_back_to_back;
    int d;
    bad_b = '0;
    run_b(1'b0, 8, d);
    total++;
    if (d != 20 || pass_b !== 1'b1) begin
      bad++;
      $display("FAIL midrun_start got done=%0d pass=%0d want 20 1", d, pass_b);
    end
    run_b(1'b0, 19, d);
    repeat (4) @(negedge clk);
    total++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || stim_b !== 4'hf) begin
      bad++;
      $display("FAIL edge_start got done=%0d busy=%0d stim=%0d want 1 0 15",
               done_b, busy_b, stim_b);
    end
    bad_b = 16'h0008;
    run_b(1'b0, 0, d);
    total++;
    if (d != 20 || err_b !== 4'd1 || fvec_b !== 4'd3) begin
      bad++;
      $display("FAIL from_done got done=%0d err=%0d vec=%0d want 20 1 3",
               d, err_b, fvec_b);
    end
  endtask

  task automatic test_reset_midrun;
    int d;
    int v1, v2;
    v1 = $urandom_range(1, 40);
    v2 = $urandom_range(41, 90);
    bad_a     = '0;
    bad_a[v1] = 1'b1;
    bad_a[v2] = 1'b1;
    stop_a    = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    total++;
    if (err_a !== 16'd2 || fev_a !== 1'b1 || fvec_a !== 10'(v1)) begin
      bad++;
      $display("FAIL pre_reset got err=%0d fev=%0d vec=%0d want 2 1 %0d",
               err_a, fev_a, fvec_a, v1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({stim_a, busy_a, done_a, pass_a, err_a, fev_a, fvec_a} !== '0) begin
      bad++;
      $display("FAIL async_reset got stim=%0d busy=%0d err=%0d fev=%0d want all 0",
               stim_a, busy_a, err_a, fev_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad_a = '0;
    run_a(200, d);
    total++;
    if (d != 1025 || pass_a !== 1'b1 || err_a !== 16'd0 || a_seq_ok !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got done=%0d pass=%0d err=%0d seq=%0d want 1025 1 0 1",
               d, pass_a, err_a, a_seq_ok);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    start_a = 1'b0;
    stop_a  = 1'b0;
    start_b = 1'b0;
    stop_b  = 1'b0;
    bad_a   = '0;
    bad_b   = '0;
    mask_b  = 4'h1;
    dut_lat = 3;
    test_reset;
    test_or_sweep;
    test_latency;
    test_faults;
    test_abort;
    test_saturate;
    test_back_to_back;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exhaustive_checker.md
# exhaustive_checker

Synthesizable, parametrised self-checking stimulus engine for small combinational or shallow-pipelined blocks. On a start pulse it sweeps every input vector `0 .. 2^WIDTH-1` into the device under test. It compares the DUT output against a golden reference output, aligning the two through a configurable latency delay line, and counts mismatches. It also captures the first failing vector and reports pass/fail on completion. It sits between a DUT instance and the result logger in each lab bench, and replaces hand-written free-running counters and unchecked comparisons.

## Interface
- `WIDTH`, 10: DUT input width; the sweep covers 2^WIDTH vectors (1..16).
- `OUT_W`, 1: DUT/reference output width (1..32).
- `LAT`, 1: DUT latency in clock cycles (0..15); the reference output is delayed by this amount.
- `ERR_W`, 16: mismatch counter width; the counter saturates.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE and DONE.
- `stop_on_err` in 1: sampled together with `start`; when 1, the sweep aborts on the first mismatch.
- `stim` out WIDTH: registered vector driven to both the DUT and the reference.
- `dut_o` in OUT_W: DUT output; `LAT` cycles behind `stim`.
- `ref_o` in OUT_W: golden output; combinational from `stim`, zero latency.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: level; high in DONE until the next accepted `start`.
- `pass` out 1: valid while `done` is high; 1 iff the full sweep completed with zero mismatches.
- `err_cnt` out ERR_W: saturating mismatch count.
- `first_err_valid` out 1: a mismatch has been captured this run.
- `first_err_vec` out WIDTH: vector of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE/DONE + `start`: go to RUN. `stim`, `err_cnt`, `first_err_*`, `done` and `pass` clear; `stop_on_err` is latched.
- RUN: `stim` increments by 1 per cycle. Each issued vector and its `ref_o` enter the delay line tagged valid. After issuing all-ones, go to DRAIN if `LAT>0`, otherwise go to DONE.
- DRAIN: `stim` holds all-ones and issues no new valid tags. The state lasts exactly `LAT` cycles, then goes to DONE.
- Compare: on each valid tag emerging from the delay line, mismatch = (`dut_o` != delayed `ref_o`). On a mismatch, `err_cnt` increments, saturating at 2^ERR_W-1. The first mismatch also sets `first_err_valid` and captures the delayed vector into `first_err_vec`.
- Abort: with latched `stop_on_err`, the first mismatch goes straight to DONE with `pass`=0. The delay line is flushed, and in-flight vectors are neither compared nor counted.
- `start` is ignored in RUN and DRAIN.
- `pass` = full sweep completed AND `err_cnt`==0. An abort always gives `pass`=0.
- Reset mid-run: everything returns to reset values immediately and the delay-line valid tags clear. There is no resumption.
- Arithmetic:
  - `stim` wraps naturally at 2^WIDTH, but wrap is never reached in RUN because the state changes on all-ones.
  - `err_cnt` never wraps.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_valid`=0, `first_err_vec`=0, delay line all invalid.
- `start` sampled high at edge t: `stim`=0 and `busy`=1 during cycle t+1. Vector k is presented in cycle t+1+k.
- Vector k is compared in cycle t+1+k+LAT, and its `err_cnt` update is visible in cycle t+2+k+LAT.
- Normal completion: `done`=1 and `busy`=0 from cycle t+1+2^WIDTH+LAT.
- Abort: a mismatch compared in cycle c gives `done`=1 in cycle c+1.
- `start` in the same cycle as `done` rising is ignored; `start` sampled while already in DONE is accepted.

## Structure
- Package `checker_pkg`:
  - `chk_state_t` enum (IDLE, RUN, DRAIN, DONE);
  - `LAT_MAX`=15;
  - saturating-increment function.
- Sub-module `delay_line`:
  - parameters DW and DEPTH;
  - shift register of {valid, vector, ref_o};
  - DEPTH=0 is a pass-through;
  - has a synchronous flush input.
- Top level: FSM, stimulus counter, comparator, error capture.

## Test plan
- OR-gate DUT, WIDTH=10, LAT=0, `start` at cycle 0 -> vectors 0..1023 issued; `done` at cycle 1025; `pass`=1; `err_cnt`=0.
- Registered DUT, LAT=3, WIDTH=4 -> `done` at cycle 20; `pass`=1. With LAT set to 2 instead, mismatches are reported (alignment check).
- DUT forced wrong on vectors 5 and 9, WIDTH=4, `stop_on_err`=0 -> `err_cnt`=2; `first_err_vec`=5; `pass`=0; `done` at normal cycle.
- Same fault with `stop_on_err`=1, LAT=1 -> vector 5 is compared at cycle 7 and `done`=1 at cycle 8; `err_cnt`=1; no later counts.
- ERR_W=4, DUT always wrong, WIDTH=5 -> `err_cnt` stays at 15 and never wraps; `first_err_vec`=0.
- `rst_n` low at cycle 100 of a WIDTH=10 sweep -> all outputs at reset values at once. A new `start` then completes a clean sweep with `pass`=1. `start` pulsed mid-RUN has no effect.
